// File: rtl/wrr_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | wrr_arbiter_if                                                             |
// | Requester/resource handshake bundle for the weighted round-robin arbiter.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface wrr_arbiter_if #(
  parameter int N = 4
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  req;
  logic          ack;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic          timeout;

  // Requesters plus resource drive req/ack; the arbiter drives the grant side.
  modport master (
    output req,
    output ack,
    input  grant,
    input  grant_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  ack,
    output grant,
    output grant_id,
    output busy,
    output timeout
  );
endinterface

`default_nettype wire

// File: rtl/wrr_arbiter.sv
// +----------------------------------------------------------------------------+
// | wrr_arbiter                                                                |
// | Weighted round-robin arbiter, grant held per transaction until ack.        |
// | Optional grant-hold timeout enabled by macro WRR_TIMEOUT_EN.               |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module wrr_arbiter #(
  parameter int N       = 4,
  parameter int WW      = 3,
  parameter int TIMEOUT = 64
) (
  input  wire                 clk,
  input  wire                 rst_an,
  wrr_arbiter_if.slave        bus,
  input  wire                 cfg_we,
  input  wire [$clog2(N)-1:0] cfg_idx,
  input  wire [WW-1:0]        cfg_weight
);

  localparam int IW = $clog2(N);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] winner;
  logic [IW-1:0] next_ptr;
  logic          found;
  logic [WW-1:0] credit;
  logic [WW-1:0] credit_dec;
  logic [WW-1:0] load_weight;
  logic [WW-1:0] weight [N];
  logic [N-1:0]  grant_vec;
  logic          busy_flag;
  logic [IW:0]   scan_idx;

  // First requester at or above ptr, wrapping past N-1 back to 0.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int i = 0; i < N; i++) begin
      scan_idx = {1'b0, ptr} + (IW+1)'(i);
      if (scan_idx >= (IW+1)'(N)) begin
        scan_idx = scan_idx - (IW+1)'(N);
      end
      if (!found && bus.req[scan_idx[IW-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[IW-1:0];
      end
    end
  end

  assign load_weight = (weight[winner] == '0) ? WW'(1) : weight[winner];
  assign credit_dec  = credit - WW'(1);
  assign next_ptr    = (owner == IW'(N-1)) ? '0 : owner + IW'(1);

  // The load reads the pre-write value, so a same-cycle write applies next load.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      for (int i = 0; i < N; i++) begin
        weight[i] <= WW'(1);
      end
    end else if (cfg_we) begin
      weight[cfg_idx] <= cfg_weight;
    end
  end

`ifdef WRR_TIMEOUT_EN
  localparam int HW = $clog2(TIMEOUT + 1);
  logic [HW-1:0] hold_cnt;
  logic          timeout_flag;
`endif

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      credit    <= '0;
      grant_vec <= '0;
      busy_flag <= 1'b0;
`ifdef WRR_TIMEOUT_EN
      hold_cnt     <= '0;
      timeout_flag <= 1'b0;
`endif
    end else begin
`ifdef WRR_TIMEOUT_EN
      timeout_flag <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            state     <= GRANT;
            grant_vec <= N'(1) << winner;
            owner     <= winner;
            busy_flag <= 1'b1;
            // A returning pointer owner with credit left continues its burst.
            if (!(winner == ptr && credit != '0)) begin
              credit <= load_weight;
              ptr    <= winner;
            end
`ifdef WRR_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        GRANT: begin
          if (bus.ack) begin
            state     <= IDLE;
            grant_vec <= '0;
            busy_flag <= 1'b0;
            credit    <= credit_dec;
            if (credit_dec == '0) begin
              ptr <= next_ptr;
            end
          end
`ifdef WRR_TIMEOUT_EN
          else if (hold_cnt == HW'(TIMEOUT - 1)) begin
            state        <= IDLE;
            grant_vec    <= '0;
            busy_flag    <= 1'b0;
            timeout_flag <= 1'b1;
            credit       <= '0;
            ptr          <= next_ptr;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant    = grant_vec;
  assign bus.grant_id = owner;
  assign bus.busy     = busy_flag;
`ifdef WRR_TIMEOUT_EN
  assign bus.timeout  = timeout_flag;
`else
  assign bus.timeout  = 1'b0;
`endif

endmodule

`default_nettype wire
